// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate decoder with a registered output stage, a
// one-entry skid slot behind it, and a saturating count of accepted illegal opcodes.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  localparam bit IS64 = (XLEN == 64);

  occ_e             state_q, state_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  fmt_e             out_fmt_q, out_fmt_d, skid_fmt_q, skid_fmt_d;
  logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic [31:0]      out_inst_q, out_inst_d, skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;
  logic             fire_in;

  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    unique case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_fmt = FMT_I;
        imm32   = {{21{in_inst[31]}}, in_inst[30:20]};
      end
      7'b0011011: begin
        if (IS64) begin
          dec_fmt = FMT_I;
          imm32   = {{21{in_inst[31]}}, in_inst[30:20]};
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110011: ;
      7'b0111011: dec_ill = !IS64;
      default:    dec_ill = 1'b1;
    endcase
    // Sign-extending cast covers the U-type widening above bit 31 when XLEN=64.
    dec_imm = XLEN'($signed(imm32));
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign fire_in   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_imm_d   = out_imm_q;
    out_fmt_d   = out_fmt_q;
    out_ill_d   = out_ill_q;
    out_inst_d  = out_inst_q;
    skid_imm_d  = skid_imm_q;
    skid_fmt_d  = skid_fmt_q;
    skid_ill_d  = skid_ill_q;
    skid_inst_d = skid_inst_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (fire_in) state_d = ONE;
      end
      ONE: begin
        if (out_ready)    state_d = fire_in ? ONE : EMPTY;
        else if (fire_in) state_d = TWO;
      end
      TWO: begin
        if (out_ready) begin
          state_d     = ONE;
          out_imm_d   = skid_imm_q;
          out_fmt_d   = skid_fmt_q;
          out_ill_d   = skid_ill_q;
          out_inst_d  = skid_inst_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A new beat goes straight to the output stage unless it is stalled, then to skid.
    if (fire_in) begin
      if (state_q == EMPTY || out_ready) begin
        out_imm_d  = dec_imm;
        out_fmt_d  = dec_fmt;
        out_ill_d  = dec_ill;
        out_inst_d = in_inst;
      end else begin
        skid_imm_d  = dec_imm;
        skid_fmt_d  = dec_fmt;
        skid_ill_d  = dec_ill;
        skid_inst_d = in_inst;
      end
    end

    if (cnt_clr)                              cnt_d = '0;
    else if (fire_in && dec_ill && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_R;
      out_ill_q   <= 1'b0;
      out_inst_q  <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_R;
      skid_ill_q  <= 1'b0;
      skid_inst_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_ill_q   <= out_ill_d;
      out_inst_q  <= out_inst_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
      skid_inst_q <= skid_inst_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_inst    = out_inst_q;
  assign illegal_cnt = cnt_q;

endmodule
